chunked_adder_seq: RTL and testbench



---
 rtl/chunked_adder_seq.sv | 99 +++++++++
 tb/tb_chunked_adder_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: multi-cycle DATA_W-bit adder, one CHUNK_W slice per cycle, valid/ready on both sides
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, c_in; out_valid/out_ready with sum, c_out; busy.
// Optional SEQ_ADDER_SUB_EN adds input sub (a-b) and output ovf (signed overflow).
module chunked_adder_seq #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
`ifdef SEQ_ADDER_SUB_EN
  input  logic              sub,
  output logic              ovf,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  output logic              busy
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("DATA_W must be a multiple of CHUNK_W");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state;
  logic [DATA_W-1:0]  a_r, b_r, b_in;
  logic [IDX_W-1:0]   idx;
  logic               carry, carry_in, last, msb_cin;
  logic [31:0]        base;
  logic [CHUNK_W:0]   slice;
`ifdef SEQ_ADDER_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = sub | c_in;
`else
  assign b_in     = b;
  assign carry_in = c_in;
`endif
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign base     = 32'(idx) * 32'(CHUNK_W);
  assign last     = idx == IDX_W'(NCHUNK - 1);
  assign slice    = {1'b0, a_r[base +: CHUNK_W]} + {1'b0, b_r[base +: CHUNK_W]} + (CHUNK_W+1)'(carry);
  // carry into the MSB, recovered from the MSB sum bit; only meaningful on the last slice
  assign msb_cin  = a_r[DATA_W-1] ^ b_r[DATA_W-1] ^ slice[CHUNK_W-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b_in;
          carry <= carry_in;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[base +: CHUNK_W] <= slice[CHUNK_W-1:0];
          carry                <= slice[CHUNK_W];
          if (last) begin
            c_out     <= slice[CHUNK_W];
`ifdef SEQ_ADDER_SUB_EN
            ovf       <= msb_cin ^ slice[CHUNK_W];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifndef SEQ_ADDER_SUB_EN
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif
endmodule

// File: tb/tb_chunked_adder_seq.sv
// tb_chunked_adder_seq: scoreboard bench for chunked_adder_seq with default parameters
module tb_chunked_adder_seq;
  localparam int NCHUNK = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, c_in = 1'b0, out_valid, out_ready = 1'b0, c_out, busy;
  logic [63:0] a = '0, b = '0, sum;
  logic        sub = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
  logic        ovf;
`endif
  int vectors = 0, miscompares = 0;
  typedef struct {logic [63:0] s; logic c; logic o;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  chunked_adder_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub), .ovf(ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc, input logic ts,
                        input int stall, input bit scramble);
    exp_t e;
    logic [64:0] full;
    logic [63:0] bo;
    int lat;
    bo   = ts ? ~tb_v : tb_v;
    full = {1'b0, ta} + {1'b0, bo} + 65'(ts ? 1'b1 : tc);
    e.s  = full[63:0];
    e.c  = full[64];
    e.o  = (ta[63] == bo[63]) && (e.s[63] != ta[63]);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = ~c_in; sub = ~sub; end
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 64'(lat), 64'(NCHUNK));
    if (!out_valid) begin q.pop_front(); return; end
    check("busy_in_done", 64'(busy), 64'd1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_sum", sum, e.s);
    end
    e = q.pop_front();
    check("sum", sum, e.s);
    check("c_out", 64'(c_out), 64'(e.c));
`ifdef SEQ_ADDER_SUB_EN
    check("ovf", 64'(ovf), 64'(e.o));
`endif
    @(negedge clk);
    check("in_ready_at_handshake", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
    check("sum_held_after_hs", sum, e.s);
    sub = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 0);
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 0);
    run_op(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 0);
    run_op(64'd3, 64'd4, 1'b0, 1'b0, 5, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0, 0);
    run_op(64'd10, 64'd20, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, i, 0);
    // abort mid-operation: partial slices are nonzero before reset hits
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum", sum, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_c_out", 64'(c_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_abort_in_ready", 64'(in_ready), 64'd1);
    run_op(64'd1, 64'd1, 1'b0, 1'b0, 0, 0);
`ifdef SEQ_ADDER_SUB_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 0);
`endif
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
